// File: rtl/sa_pkg.sv
// sa_pkg: shared types and default widths for the systolic operand feeder.
// Holds the tile FSM state enum and the default operand / beat-count widths.
package sa_pkg;

    localparam int SA_ELEM_BITS = 8;
    localparam int SA_K_BITS    = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_FLUSH,
        ST_DONE
    } sa_feed_state_e;

endpackage

// File: rtl/sa_skew_line.sv
// sa_skew_line: DEPTH-stage data+valid delay line, advancing when i_en is high.
// Ports: clk, rstn, i_en, i_data/i_valid in, o_data/o_valid out after DEPTH shifts.
module sa_skew_line #(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_en,
    input  logic [W-1:0] i_data,
    input  logic         i_valid,
    output logic [W-1:0] o_data,
    output logic         o_valid
);

    logic [W-1:0]     r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_data[k] <= '0;
            end
            r_valid <= '0;
        end else if (i_en) begin
            r_data[0]  <= i_data;
            r_valid[0] <= i_valid;
            for (int k = 1; k < DEPTH; k++) begin
                r_data[k]  <= r_data[k-1];
                r_valid[k] <= r_valid[k-1];
            end
        end
    end

    assign o_data  = r_data[DEPTH-1];
    assign o_valid = r_valid[DEPTH-1];

endmodule

// File: rtl/sa_operand_skewer.sv
// sa_operand_skewer: diagonal-skew feeder for the INT8 systolic array with a
// clear/stream/flush/done tile FSM. Inputs: start, k_len, a_vec/b_vec with
// valid/ready. Outputs: a_row/b_col + valids, clr, shift_en, busy, done.
// Optional stall_cnt output when SA_FEEDER_STALL_CNT_EN is defined.
module sa_operand_skewer
    import sa_pkg::*;
#(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int ELEM_BITS = SA_ELEM_BITS,
    parameter int K_BITS    = SA_K_BITS
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic [K_BITS-1:0]         k_len,
    input  logic [ROWS*ELEM_BITS-1:0] a_vec,
    input  logic                      a_valid,
    output logic                      a_ready,
    input  logic [COLS*ELEM_BITS-1:0] b_vec,
    input  logic                      b_valid,
    output logic                      b_ready,
    output logic [ROWS*ELEM_BITS-1:0] a_row,
    output logic [ROWS-1:0]           a_v_row,
    output logic [COLS*ELEM_BITS-1:0] b_col,
    output logic [COLS-1:0]           b_v_col,
    output logic                      clr,
    output logic                      shift_en,
    output logic                      busy,
`ifdef SA_FEEDER_STALL_CNT_EN
    output logic [15:0]               stall_cnt,
`endif
    output logic                      done
);

    localparam int FLUSH_LEN = ROWS + COLS - 1;
    localparam int FL_W      = $clog2(FLUSH_LEN + 1);

    localparam logic [FL_W-1:0]   FL_LAST = FL_W'(FLUSH_LEN - 1);
    localparam logic [FL_W-1:0]   FL_ONE  = FL_W'(1);
    localparam logic [K_BITS-1:0] K_ONE   = K_BITS'(1);

    sa_feed_state_e r_state;
    sa_feed_state_e w_state_nxt;

    logic [K_BITS-1:0] r_beat_cnt;
    logic [FL_W-1:0]   r_flush_cnt;

    logic w_stream;
    logic w_fire;
    logic w_busy;
    logic w_take_start;

    logic [ROWS*ELEM_BITS-1:0] w_a_in;
    logic [COLS*ELEM_BITS-1:0] w_b_in;

    assign w_stream     = (r_state == ST_STREAM);
    assign w_fire       = w_stream & a_valid & b_valid;
    assign w_busy       = (r_state != ST_IDLE);
    assign w_take_start = (r_state == ST_IDLE) & start;

    // Each side's ready depends on the other's valid, so a beat is only
    // ever taken from both sides together.
    assign a_ready  = w_stream & b_valid;
    assign b_ready  = w_stream & a_valid;
    assign clr      = (r_state == ST_CLEAR);
    assign done     = (r_state == ST_DONE);
    assign busy     = w_busy;
    assign shift_en = w_busy;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                w_state_nxt = (r_beat_cnt == '0) ? ST_DONE : ST_STREAM;
            end
            ST_STREAM: begin
                if (w_fire && r_beat_cnt == K_ONE) w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (r_flush_cnt == FL_LAST) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_beat_cnt  <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_take_start) begin
                r_beat_cnt <= k_len;
            end else if (w_fire) begin
                r_beat_cnt <= r_beat_cnt - K_ONE;
            end
            if (r_state == ST_FLUSH) begin
                r_flush_cnt <= r_flush_cnt + FL_ONE;
            end else begin
                r_flush_cnt <= '0;
            end
        end
    end

`ifdef SA_FEEDER_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cnt <= '0;
        end else if (w_take_start) begin
            r_stall_cnt <= '0;
        end else if (w_stream && !w_fire && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    // Non-beat cycles enter the lines as zero-data bubbles so the
    // diagonal wavefront stays aligned across rows and columns.
    assign w_a_in = w_fire ? a_vec : '0;
    assign w_b_in = w_fire ? b_vec : '0;

    for (genvar i = 0; i < ROWS; i++) begin : g_a_lane
        sa_skew_line #(
            .DEPTH (i + 1),
            .W     (ELEM_BITS)
        ) u_a_line (
            .clk     (clk),
            .rstn    (rstn),
            .i_en    (w_busy),
            .i_data  (w_a_in[i*ELEM_BITS +: ELEM_BITS]),
            .i_valid (w_fire),
            .o_data  (a_row[i*ELEM_BITS +: ELEM_BITS]),
            .o_valid (a_v_row[i])
        );
    end

    for (genvar j = 0; j < COLS; j++) begin : g_b_lane
        sa_skew_line #(
            .DEPTH (j + 1),
            .W     (ELEM_BITS)
        ) u_b_line (
            .clk     (clk),
            .rstn    (rstn),
            .i_en    (w_busy),
            .i_data  (w_b_in[j*ELEM_BITS +: ELEM_BITS]),
            .i_valid (w_fire),
            .o_data  (b_col[j*ELEM_BITS +: ELEM_BITS]),
            .o_valid (b_v_col[j])
        );
    end

endmodule
